// File: rtl/mk1kbd_pkg.sv
// MEGA65 MK-I keyboard responder: shared constants and FSM state type.
// Imported by mk1kbd_edge_sync and mk1kbd_responder.
package mk1kbd_pkg;

  localparam int MK1_FRAME_BITS = 128;
  localparam int MK1_LED_BITS   = 96;
  localparam int MK1_KEY_BITS   = 80;

  localparam int MK1_LED1_OFS = 0;
  localparam int MK1_LED2_OFS = 24;
  localparam int MK1_LED3_OFS = 48;
  localparam int MK1_LED4_OFS = 72;

  typedef enum logic [1:0] {
    HUNT,
    ARMED,
    SHIFT
  } mk1_state_e;

endpackage

// File: rtl/mk1kbd_edge_sync.sv
// Synchroniser for the master link clock and data,
// with registered rise/fall strobes aligned to the data sample.
module mk1kbd_edge_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic ck_i,
  input  logic do_i,
  output logic ck_o,
  output logic do_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] ck_sq;
  logic [STAGES-1:0] do_sq;
  logic              ck_prev_q;
  logic              rise_q;
  logic              fall_q;
  logic              do_q;

  // Idle link clock is high, so reset the chain high to avoid a false rise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ck_sq     <= '1;
      do_sq     <= '0;
      ck_prev_q <= 1'b1;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
      do_q      <= 1'b0;
    end else begin
      ck_sq     <= {ck_sq[STAGES-2:0], ck_i};
      do_sq     <= {do_sq[STAGES-2:0], do_i};
      ck_prev_q <= ck_sq[STAGES-1];
      rise_q    <= ck_sq[STAGES-1] & ~ck_prev_q;
      fall_q    <= ~ck_sq[STAGES-1] & ck_prev_q;
      do_q      <= do_sq[STAGES-1];
    end
  end

  assign ck_o   = ck_sq[STAGES-1];
  assign do_o   = do_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/mk1kbd_responder.sv
// Keyboard-side responder for the MEGA65 MK-I serial link.
// Optional frame statistics: define MK1KBD_FRAME_STATS_EN.
module mk1kbd_responder
  import mk1kbd_pkg::*;
#(
  parameter int SYNC_CYCLES = 64,
  parameter int CDC_STAGES  = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    kb_ck,
  input  logic                    kb_do,
  output logic                    kb_di,
  input  logic [0:MK1_KEY_BITS-1] key_matrix,
  output logic [0:23]             led1_rgb,
  output logic [0:23]             led2_rgb,
  output logic [0:23]             led3_rgb,
  output logic [0:23]             led4_rgb,
  output logic                    frame_done,
  output logic [15:0]             frame_count,
  output logic [7:0]              short_frames
);

  localparam int GW = $clog2(SYNC_CYCLES + 1);
  localparam logic [GW-1:0] GAP_MAX = GW'(SYNC_CYCLES);
  localparam logic [6:0] LAST   = 7'(MK1_FRAME_BITS - 1);
  localparam logic [6:0] KEYS_N = 7'(MK1_KEY_BITS);
  localparam logic [6:0] LEDS_N = 7'(MK1_LED_BITS);

  logic ck_s, do_s, rise, fall;

  mk1kbd_edge_sync #(
    .STAGES (CDC_STAGES)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .ck_i    (kb_ck),
    .do_i    (kb_do),
    .ck_o    (ck_s),
    .do_o    (do_s),
    .rise_o  (rise),
    .fall_o  (fall)
  );

  mk1_state_e                state_q, state_d;
  logic [GW-1:0]             gap_q, gap_d;
  logic [6:0]                idx_q, idx_n;
  logic [0:MK1_LED_BITS-1]   shadow_q;
  logic [0:MK1_LED_BITS-1]   leds_q;
  logic [0:MK1_KEY_BITS-1]   snap_q;
  logic                      kb_di_q;
  logic                      done_q;
  logic                      gap_hit;
  logic                      arm, done, cap, adv;
  logic                      nxt_bit;

  assign gap_hit = (gap_q == GAP_MAX);
  assign idx_n   = idx_q + 7'd1;
  assign nxt_bit = (idx_n < KEYS_N) ? ~snap_q[idx_n] : 1'b1;

  // Gap counter: saturating run length of synchronised clock-high.
  always_comb begin
    gap_d = gap_q;
    if (!ck_s)
      gap_d = '0;
    else if (!gap_hit)
      gap_d = gap_q + 1'b1;
  end

  // Next-state and frame control strobes.
  always_comb begin
    state_d = state_q;
    arm     = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      HUNT: begin
        if (gap_hit) begin
          state_d = ARMED;
          arm     = 1'b1;
        end
      end
      ARMED: begin
        if (rise)
          state_d = SHIFT;
      end
      SHIFT: begin
        if (gap_hit) begin
          state_d = ARMED;
          arm     = 1'b1;
        end else if (fall && idx_q == LAST) begin
          state_d = HUNT;
          done    = 1'b1;
        end
      end
      default: state_d = HUNT;
    endcase
    cap = rise && (state_q != HUNT) && !arm;
    adv = fall && (state_q == SHIFT) && !gap_hit && (idx_q != LAST);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state_q <= HUNT;
    else
      state_q <= state_d;
  end

  // Snapshot, shift datapath, outbound bit and LED frame latch.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gap_q    <= '0;
      idx_q    <= '0;
      shadow_q <= '0;
      leds_q   <= '0;
      snap_q   <= '0;
      kb_di_q  <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      gap_q  <= gap_d;
      done_q <= done;
      if (arm) begin
        snap_q   <= key_matrix;
        idx_q    <= '0;
        kb_di_q  <= ~key_matrix[0];
        shadow_q <= '0;
      end else begin
        if (cap && idx_q < LEDS_N)
          shadow_q[idx_q] <= do_s;
        if (adv) begin
          idx_q   <= idx_n;
          kb_di_q <= nxt_bit;
        end
        if (done) begin
          leds_q  <= shadow_q;
          kb_di_q <= 1'b1;
        end
      end
    end
  end

  assign kb_di      = kb_di_q;
  assign frame_done = done_q;
  assign led1_rgb   = leds_q[MK1_LED1_OFS +: 24];
  assign led2_rgb   = leds_q[MK1_LED2_OFS +: 24];
  assign led3_rgb   = leds_q[MK1_LED3_OFS +: 24];
  assign led4_rgb   = leds_q[MK1_LED4_OFS +: 24];

`ifdef MK1KBD_FRAME_STATS_EN
  logic [15:0] fcnt_q;
  logic [7:0]  scnt_q;
  logic        abort;

  assign abort = (state_q == SHIFT) && gap_hit;

  // Accepted frames wrap; aborted frames saturate.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fcnt_q <= '0;
      scnt_q <= '0;
    end else begin
      if (done)
        fcnt_q <= fcnt_q + 16'd1;
      if (abort && scnt_q != 8'hFF)
        scnt_q <= scnt_q + 8'd1;
    end
  end

  assign frame_count  = fcnt_q;
  assign short_frames = scnt_q;
`else
  assign frame_count  = '0;
  assign short_frames = '0;
`endif

endmodule

// File: tb/tb_mk1kbd_responder.sv
// Directed bench for mk1kbd_responder: link master model,
// vector table of full frames plus short/toggle/reset sequences.
module tb_mk1kbd_responder;

  localparam int L = 6;
  localparam int H = 6;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        kb_ck, kb_do, kb_di;
  logic [0:79] key_matrix;
  logic [0:23] led1_rgb, led2_rgb, led3_rgb, led4_rgb;
  logic        frame_done;
  logic [15:0] frame_count;
  logic [7:0]  short_frames;

  mk1kbd_responder dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .kb_ck        (kb_ck),
    .kb_do        (kb_do),
    .kb_di        (kb_di),
    .key_matrix   (key_matrix),
    .led1_rgb     (led1_rgb),
    .led2_rgb     (led2_rgb),
    .led3_rgb     (led3_rgb),
    .led4_rgb     (led4_rgb),
    .frame_done   (frame_done),
    .frame_count  (frame_count),
    .short_frames (short_frames)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;
  int exp_frames = 0;
  int exp_short  = 0;

  always @(posedge clk) if (frame_done) done_cnt <= done_cnt + 1;

  typedef struct {
    logic [0:79] keys;
    logic [0:95] leds;
  } vec_t;

  vec_t tbl[4];

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic gap(input int n);
    kb_ck = 1'b1;
    cyc(n);
  endtask

  task automatic run_bits(input logic [0:127] tx, input int n,
                          input int tog, output logic [0:127] rx);
    rx = '1;
    for (int k = 0; k < n; k++) begin
      kb_ck = 1'b0;
      kb_do = tx[k];
      if (k == tog) key_matrix[5] = ~key_matrix[5];
      cyc(L);
      rx[k] = kb_di;
      kb_ck = 1'b1;
      cyc(H);
    end
  endtask

  task automatic tail();
    kb_ck = 1'b0;
    cyc(10);
  endtask

  function automatic logic [0:127] exp_rx(input logic [0:79] k);
    return {~k, {48{1'b1}}};
  endfunction

  function automatic logic [0:95] leds_now();
    return {led1_rgb, led2_rgb, led3_rgb, led4_rgb};
  endfunction

  task automatic full_frame(input logic [0:95] leds, input int tog,
                            output logic [0:127] rx);
    gap(80);
    run_bits({leds, 32'h5A5A_5A5A}, 128, tog, rx);
    tail();
  endtask

  logic [0:127] rx;
  logic [0:95]  prev;
  int           d0;

  initial begin
    tbl[0].keys = '0;
    tbl[0].keys[0]  = 1'b1;
    tbl[0].keys[79] = 1'b1;
    tbl[0].leds = '0;
    tbl[1].keys = '0;
    tbl[1].leds = {24'hFF0000, 24'h0, 24'h0, 24'h0000AA};
    tbl[2].keys = 80'hAAAA_5555_F0F0_0F0F_1234;
    tbl[2].leds = 96'h123456_789ABC_DEF012_345678;
    tbl[3].keys = '1;
    tbl[3].leds = '1;

    reset_n = 1'b0;
    kb_ck = 1'b1;
    kb_do = 1'b0;
    key_matrix = tbl[0].keys;
    cyc(3);
    chk("rst_kb_di", kb_di, 1);
    chk("rst_leds", leds_now(), 0);
    chk("rst_done", frame_done, 0);
    chk("rst_fcnt", frame_count, 0);
    chk("rst_scnt", short_frames, 0);
    reset_n = 1'b1;

    cyc(30);
    chk("hunt_kb_di", kb_di, 1);
    cyc(70);
    chk("armed_kb_di", kb_di, 0);
    chk("idle_leds", leds_now(), 0);

    for (int i = 0; i < 4; i++) begin
      key_matrix = tbl[i].keys;
      d0 = done_cnt;
      full_frame(tbl[i].leds, -1, rx);
      exp_frames++;
      chk($sformatf("v%0d_rx", i), rx, exp_rx(tbl[i].keys));
      chk($sformatf("v%0d_led1", i), led1_rgb, tbl[i].leds[0:23]);
      chk($sformatf("v%0d_led2", i), led2_rgb, tbl[i].leds[24:47]);
      chk($sformatf("v%0d_led3", i), led3_rgb, tbl[i].leds[48:71]);
      chk($sformatf("v%0d_led4", i), led4_rgb, tbl[i].leds[72:95]);
      chk($sformatf("v%0d_done", i), done_cnt - d0, 1);
      chk($sformatf("v%0d_kb_di_idle", i), kb_di, 1);
    end

    // Short frame: gap after 60 bits.
    prev = tbl[3].leds;
    key_matrix = tbl[1].keys;
    d0 = done_cnt;
    gap(80);
    run_bits({96'h0F0F0F_0F0F0F_0F0F0F_0F0F0F, 32'h0}, 60, -1, rx);
    gap(100);
    exp_short++;
    chk("short_leds", leds_now(), prev);
    chk("short_done", done_cnt - d0, 0);
`ifdef MK1KBD_FRAME_STATS_EN
    chk("short_scnt", short_frames, 8'(exp_short));
`else
    chk("short_scnt", short_frames, 0);
`endif
    d0 = done_cnt;
    full_frame(tbl[2].leds, -1, rx);
    exp_frames++;
    chk("after_short_leds", leds_now(), tbl[2].leds);
    chk("after_short_rx", rx, exp_rx(tbl[1].keys));
    chk("after_short_done", done_cnt - d0, 1);

    // Key 5 changes at bit 20: visible only in the next frame.
    key_matrix = '0;
    full_frame(tbl[1].leds, 20, rx);
    exp_frames++;
    chk("tog_old_rx", rx, exp_rx(80'h0));
    full_frame(tbl[1].leds, -1, rx);
    exp_frames++;
    chk("tog_new_rx", rx, exp_rx(80'h0400_0000_0000_0000_0000));

    // Reset mid-frame at bit 50, then edges without a gap.
    key_matrix = tbl[0].keys;
    gap(80);
    run_bits({tbl[3].leds, 32'h0}, 50, -1, rx);
    reset_n = 1'b0;
    cyc(2);
    reset_n = 1'b1;
    chk("mrst_kb_di", kb_di, 1);
    chk("mrst_leds", leds_now(), 0);
    chk("mrst_done", frame_done, 0);
    chk("mrst_fcnt", frame_count, 0);
    exp_frames = 0;
    exp_short  = 0;
    d0 = done_cnt;
    run_bits({tbl[3].leds, 32'h0}, 128, -1, rx);
    tail();
    chk("post_rst_rx", rx, {128{1'b1}});
    chk("post_rst_leds", leds_now(), 0);
    chk("post_rst_done", done_cnt - d0, 0);

    d0 = done_cnt;
    full_frame(tbl[2].leds, -1, rx);
    exp_frames++;
    chk("recover_rx", rx, exp_rx(tbl[0].keys));
    chk("recover_leds", leds_now(), tbl[2].leds);
    chk("recover_done", done_cnt - d0, 1);
`ifdef MK1KBD_FRAME_STATS_EN
    chk("final_fcnt", frame_count, 16'(exp_frames));
    chk("final_scnt", short_frames, 8'(exp_short));
`else
    chk("final_fcnt", frame_count, 0);
    chk("final_scnt", short_frames, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mk1kbd_responder.md
# mk1kbd_responder

Keyboard-side responder for the MEGA65 MK-I keyboard serial link, the counterpart of the FPGA-side link master. It recovers the master-driven link clock and captures the 96 LED colour bits the master shifts out. It serialises an 80-key matrix snapshot back to the master. It is used as a synthesisable keyboard model in system simulation and as a loopback target on boards without the physical keyboard.

## Interface
Parameters:
- SYNC_CYCLES, 64: consecutive `clk` cycles with synchronised `kb_ck` high that mark an inter-frame gap.
- CDC_STAGES, 2: synchroniser depth on `kb_ck` and `kb_do`; minimum 2.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset; one clock, reset asynchronous active-low (already decided).
- kb_ck  in  1  link clock from master, asynchronous to `clk`.
- kb_do  in  1  master-to-keyboard data (LED bits).
- kb_di  out  1  keyboard-to-master data; active-low key state on the wire.
- key_matrix  in  [0:79]  1 = key pressed.
- led1_rgb..led4_rgb  out  [0:23] each  last complete LED frame.
- frame_done  out  1  one-cycle pulse when a full frame is accepted.
- frame_count  out  16  accepted frames (see Configuration).
- short_frames  out  8  aborted frames (see Configuration).

## Operation
- Frame: 128 bit slots. The master samples `kb_di` and this block samples `kb_do` on the rising `kb_ck` edge. Both sides change data after the falling edge.
- Inbound bits 0..95 map to `led1_rgb[0:23]`, `led2_rgb`, `led3_rgb`, `led4_rgb`. Bits 96..127 are ignored.
- Outbound bit k (k<80) is `~key_snapshot[k]`. Bits 80..127 are driven 1.
- `key_snapshot` is captured from `key_matrix` on entry to ARMED. Matrix changes mid-frame are not visible until the next frame.
- FSM:
  - HUNT (reset state): ignore edges; when the gap counter reaches SYNC_CYCLES -> ARMED.
  - ARMED: take snapshot; bit_idx=0; `kb_di` = bit 0. On the first rising edge -> SHIFT.
  - SHIFT: each rising edge stores `kb_do` into the shadow register at bit_idx. Each falling edge increments bit_idx and updates `kb_di`. On the falling edge with bit_idx==127 -> copy shadow to `led*_rgb`, pulse `frame_done`, -> HUNT.
  - Gap detected while in SHIFT (bit_idx<127) -> short frame: shadow discarded, LEDs unchanged, `short_frames`++ -> ARMED.
- Gap counter: counts while synchronised `kb_ck`=1 and saturates at SYNC_CYCLES. It clears on synchronised `kb_ck`=0.
- Counters wrap; `short_frames` saturates at 255.
- Reset values: `kb_di`=1, `led*_rgb`=0, `frame_done`=0, counters 0, state HUNT, shadow 0.
- Reset asserted mid-frame: immediate return to reset values. The partial frame is lost. A full gap is needed before the next capture.

## Timing
- Edge detect latency: CDC_STAGES+1 `clk` cycles from a `kb_ck` pin edge to the internal edge strobe.
- `kb_di` update: registered, CDC_STAGES+2 cycles after the pin falling edge.
- Master constraint: `kb_ck` high and low phases each ≥ CDC_STAGES+3 `clk` cycles. The inter-frame gap must be ≥ SYNC_CYCLES+CDC_STAGES+2 cycles high.
- `kb_do` passes through the same synchroniser depth as `kb_ck`, so the sample is aligned with the edge strobe.
- `led*_rgb` and `frame_done` update in the same cycle; LEDs then hold until the next accepted frame.
- A rising and a falling strobe never occur in the same cycle, because of the edge-detector construction.

## Configuration
- `MK1KBD_FRAME_STATS_EN` defined: `frame_count` increments on each `frame_done`; `short_frames` increments on each aborted frame.
- Not defined: both ports tied to 0 and the counter logic is removed. Frame handling is identical in both builds.

## Structure
- Package `mk1kbd_pkg` holds:
  - constants MK1_FRAME_BITS=128, MK1_LED_BITS=96, MK1_KEY_BITS=80;
  - the FSM state enum (HUNT, ARMED, SHIFT);
  - the LED bit-slot base offsets (0, 24, 48, 72).
- Sub-module `mk1kbd_edge_sync` provides the CDC_STAGES synchroniser for `kb_ck` and `kb_do`, plus rise/fall strobes. The parent keeps the FSM, gap counter and shift logic.

## Test plan
- Reset, then idle `kb_ck`=1 for 100 cycles -> `kb_di`=1, LEDs 0, state ARMED after SYNC_CYCLES.
- `key_matrix[0]`=1 and `key_matrix[79]`=1, run a full 128-bit frame -> master reads 0 in slots 0 and 79 and 1 in all other slots. `frame_done` pulses once.
- Shift LED pattern `led1`=24'hFF0000, `led4`=24'h0000AA -> outputs match after `frame_done`. Other LEDs are 0.
- Gap after 60 bits -> LEDs unchanged, no `frame_done`, `short_frames`=1 (stats build). The next full frame is accepted.
- Toggle `key_matrix[5]` at bit 20 -> current frame shows the old value; the next frame shows the new one.
- Assert `reset_n` at bit 50 -> all outputs return to reset values; edges before the following gap are ignored.
